// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings and the shift-counter width helper for univ_shift_reg.
package univ_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHUP = 2'b01;
    localparam logic [1:0] MODE_SHDN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/univ_shift_reg_dff_stage.sv
// One WIDTH-bit stage of the universal shift register with its own 4:1 next-value mux.
// Active edge chosen by NEG_EDGE; the clock itself is never inverted or gated.
module univ_shift_reg_dff_stage
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter bit               NEG_EDGE  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] up_in,
    input  logic [WIDTH-1:0] dn_in,
    input  logic [WIDTH-1:0] ld_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d;

    // Unknown or HOLD mode falls through to the default and keeps the stage.
    always_comb begin
        d = q;
        if (en) begin
            case (mode)
                MODE_SHUP: d = up_in;
                MODE_SHDN: d = dn_in;
                MODE_LOAD: d = ld_in;
                default:   d = q;
            endcase
        end
    end

    generate
        if (NEG_EDGE) begin : g_neg
            always_ff @(negedge clk or negedge reset) begin
                if (!reset) q <= RESET_VAL;
                else        q <= d;
            end
        end else begin : g_pos
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) q <= RESET_VAL;
                else        q <= d;
            end
        end
    endgenerate

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH bits with hold/shift-up/shift-down/load.
// Optional UNIV_SHIFT_REG_OVERRIDE_EN adds ovr_en/ovr_val to force q without disturbing the stages.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter bit               NEG_EDGE  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef UNIV_SHIFT_REG_OVERRIDE_EN
    input  logic                     ovr_en,
    input  logic [WIDTH*DEPTH-1:0]   ovr_val,
`else
`endif
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         sin_lo,
    input  logic [WIDTH-1:0]         sin_hi,
    input  logic [WIDTH*DEPTH-1:0]   pdata,
    output logic [WIDTH*DEPTH-1:0]   q,
    output logic [WIDTH*DEPTH-1:0]   qbar,
    output logic [WIDTH-1:0]         sout_lo,
    output logic [WIDTH-1:0]         sout_hi,
    output logic [cnt_w(DEPTH)-1:0]  shift_cnt,
    output logic                     flushed
);

    localparam int               CNT_W   = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0]       stage [DEPTH];
    logic [WIDTH*DEPTH-1:0] stages_flat;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] up_in;
        logic [WIDTH-1:0] dn_in;

        if (k == 0) begin : g_up_edge
            assign up_in = sin_lo;
        end else begin : g_up_mid
            assign up_in = stage[k-1];
        end

        if (k == DEPTH-1) begin : g_dn_edge
            assign dn_in = sin_hi;
        end else begin : g_dn_mid
            assign dn_in = stage[k+1];
        end

        univ_shift_reg_dff_stage #(
            .WIDTH     (WIDTH),
            .NEG_EDGE  (NEG_EDGE),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .mode  (mode),
            .up_in (up_in),
            .dn_in (dn_in),
            .ld_in (pdata[k*WIDTH +: WIDTH]),
            .q     (stage[k])
        );

        assign stages_flat[k*WIDTH +: WIDTH] = stage[k];
    end

    logic             shifting;
    logic [CNT_W-1:0] cnt_nxt;

    assign shifting = en && ((mode == MODE_SHUP) || (mode == MODE_SHDN));

    always_comb begin
        cnt_nxt = shift_cnt;
        if (en && (mode == MODE_LOAD))
            cnt_nxt = '0;
        else if (shifting && (shift_cnt != CNT_MAX))
            cnt_nxt = shift_cnt + 1'b1;
    end

    generate
        if (NEG_EDGE) begin : g_cnt_neg
            always_ff @(negedge clk or negedge reset) begin
                if (!reset) shift_cnt <= '0;
                else        shift_cnt <= cnt_nxt;
            end
        end else begin : g_cnt_pos
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) shift_cnt <= '0;
                else        shift_cnt <= cnt_nxt;
            end
        end
    endgenerate

    // Flags and serial taps always follow the real stages, even while q is forced.
    assign flushed = (shift_cnt == CNT_MAX);
    assign sout_lo = stage[0];
    assign sout_hi = stage[DEPTH-1];

`ifdef UNIV_SHIFT_REG_OVERRIDE_EN
    assign q = ovr_en ? ovr_val : stages_flat;
`else
    assign q = stages_flat;
`endif
    assign qbar = ~q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: negedge, posedge and single-stage instances against a word-level model.
module tb_univ_shift_reg;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] SHUP = 2'b01;
    localparam logic [1:0] SHDN = 2'b10;
    localparam logic [1:0] LOAD = 2'b11;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        en     = 1'b0;
    logic [1:0]  mode   = HOLD;
    logic [7:0]  sin_lo = 8'h00;
    logic [7:0]  sin_hi = 8'h00;
    logic [31:0] pdata  = 32'h0;
    logic        ovr_en  = 1'b0;
    logic [31:0] ovr_val = 32'h0;

    logic [31:0] q_n, qbar_n, q_p, qbar_p;
    logic [7:0]  lo_n, hi_n, lo_p, hi_p, q_1, qbar_1, lo_1, hi_1;
    logic [2:0]  cnt_n, cnt_p;
    logic [0:0]  cnt_1;
    logic        fl_n, fl_p, fl_1;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    logic [31:0] mq_n, mq_p, mq_1;
    int          mc_n, mc_p, mc_1;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .DEPTH(4), .NEG_EDGE(1'b1), .RESET_VAL(8'hA5)) dut_n (
        .clk(clk), .reset(reset),
`ifdef UNIV_SHIFT_REG_OVERRIDE_EN
        .ovr_en(ovr_en), .ovr_val(ovr_val),
`endif
        .en(en), .mode(mode), .sin_lo(sin_lo), .sin_hi(sin_hi), .pdata(pdata),
        .q(q_n), .qbar(qbar_n), .sout_lo(lo_n), .sout_hi(hi_n),
        .shift_cnt(cnt_n), .flushed(fl_n)
    );

    univ_shift_reg #(.WIDTH(8), .DEPTH(4), .NEG_EDGE(1'b0), .RESET_VAL(8'h3C)) dut_p (
        .clk(clk), .reset(reset),
`ifdef UNIV_SHIFT_REG_OVERRIDE_EN
        .ovr_en(ovr_en), .ovr_val(ovr_val),
`endif
        .en(en), .mode(mode), .sin_lo(sin_lo), .sin_hi(sin_hi), .pdata(pdata),
        .q(q_p), .qbar(qbar_p), .sout_lo(lo_p), .sout_hi(hi_p),
        .shift_cnt(cnt_p), .flushed(fl_p)
    );

    univ_shift_reg #(.WIDTH(8), .DEPTH(1), .NEG_EDGE(1'b0), .RESET_VAL(8'h5E)) dut_1 (
        .clk(clk), .reset(reset),
`ifdef UNIV_SHIFT_REG_OVERRIDE_EN
        .ovr_en(ovr_en), .ovr_val(ovr_val[7:0]),
`endif
        .en(en), .mode(mode), .sin_lo(sin_lo), .sin_hi(sin_hi), .pdata(pdata[7:0]),
        .q(q_1), .qbar(qbar_1), .sout_lo(lo_1), .sout_hi(hi_1),
        .shift_cnt(cnt_1), .flushed(fl_1)
    );

    function automatic logic [31:0] mask_of(input int depth);
        return (depth == 4) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    // Word-level view: shifting up is a multiply by 256, shifting down a divide by 256.
    function automatic logic [31:0] nxt_q(input logic [31:0] cur, input int depth);
        if (!en) return cur;
        case (mode)
            SHUP:    return ((cur << 8) | 32'(sin_lo)) & mask_of(depth);
            SHDN:    return (cur >> 8) | (32'(sin_hi) << (8 * (depth - 1)));
            LOAD:    return pdata & mask_of(depth);
            default: return cur;
        endcase
    endfunction

    function automatic int nxt_c(input int cur, input int depth);
        if (!en) return cur;
        case (mode)
            LOAD:       return 0;
            SHUP, SHDN: return (cur < depth) ? cur + 1 : depth;
            default:    return cur;
        endcase
    endfunction

    always @(negedge clk or negedge reset) begin
        if (!reset) begin mq_n = {4{8'hA5}}; mc_n = 0; end
        else begin mq_n = nxt_q(mq_n, 4); mc_n = nxt_c(mc_n, 4); end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq_p = {4{8'h3C}}; mc_p = 0;
            mq_1 = 32'h5E;     mc_1 = 0;
        end else begin
            mq_p = nxt_q(mq_p, 4); mc_p = nxt_c(mc_p, 4);
            mq_1 = nxt_q(mq_1, 1); mc_1 = nxt_c(mc_1, 1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_one(input string tag, input logic [31:0] mq, input int mc, input int depth,
                             input logic [31:0] q, input logic [31:0] qb, input logic [7:0] lo,
                             input logic [7:0] hi, input int cnt, input logic fl);
        logic [31:0] eq;
        eq = mq;
`ifdef UNIV_SHIFT_REG_OVERRIDE_EN
        if (ovr_en) eq = ovr_val & mask_of(depth);
`endif
        chk({tag, ".q"},         q,            eq);
        chk({tag, ".qbar"},      qb,           ~eq & mask_of(depth));
        chk({tag, ".sout_lo"},   32'(lo),      32'(mq[7:0]));
        chk({tag, ".sout_hi"},   32'(hi),      32'(mq[8*depth-1 -: 8]));
        chk({tag, ".shift_cnt"}, 32'(cnt),     32'(mc));
        chk({tag, ".flushed"},   32'(fl),      32'(mc == depth));
    endtask

    // Single compare process: samples 2 time units after every clock transition.
    always @(clk) begin
        #2;
        if (cmp_on) begin
            if (en === 1'b1 && $isunknown(mode)) begin
                bad++;
                $display("FAIL mode_unknown: got %b want 0/1 bits at %0t", mode, $time);
            end
            check_one("neg", mq_n, mc_n, 4, q_n, qbar_n, lo_n, hi_n, int'(cnt_n), fl_n);
            check_one("pos", mq_p, mc_p, 4, q_p, qbar_p, lo_p, hi_p, int'(cnt_p), fl_p);
            check_one("d1",  mq_1, mc_1, 1, 32'(q_1), 32'(qbar_1), lo_1, hi_1, int'(cnt_1), fl_1);
        end
    end

    // Inputs change 1 after posedge; returns 2 after the following negedge.
    task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] sl,
                         input logic [7:0] sh, input logic [31:0] pd);
        @(posedge clk);
        #1;
        en = e; mode = m; sin_lo = sl; sin_hi = sh; pdata = pd;
        @(negedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] hi_seq [4];
        hi_seq[0] = 8'h33; hi_seq[1] = 8'h22; hi_seq[2] = 8'h11; hi_seq[3] = 8'hFF;

        // Asynchronous reset mid-cycle, before any clock edge.
        #3 reset = 1'b0;
        #1;
        chk("rst.q_n",    q_n,    32'hA5A5_A5A5);
        chk("rst.qbar_n", qbar_n, 32'h5A5A_5A5A);
        chk("rst.q_p",    q_p,    32'h3C3C_3C3C);
        chk("rst.cnt_n",  32'(cnt_n), 32'd0);
        chk("rst.fl_n",   32'(fl_n),  32'd0);
        cmp_on = 1'b1;
        #4 reset = 1'b1;

        // Edge selection: negedge instance updates first, posedge instance half a cycle later.
        drive(1'b1, LOAD, 8'h00, 8'h00, 32'hCAFE_0001);
        chk("edge.q_n_after_neg", q_n, 32'hCAFE_0001);
        chk("edge.q_p_before_pos", q_p, 32'h3C3C_3C3C);
        #5;
        chk("edge.q_p_after_pos", q_p, 32'hCAFE_0001);

        // Load then shift up four times with 0xFF.
        drive(1'b1, LOAD, 8'h00, 8'h00, 32'h4433_2211);
        chk("load.sout_hi", 32'(hi_n), 32'h44);
        chk("load.cnt",     32'(cnt_n), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, SHUP, 8'hFF, 8'h00, 32'h0);
            chk("shup.sout_hi", 32'(hi_n),  32'(hi_seq[i]));
            chk("shup.cnt",     32'(cnt_n), 32'(i + 1));
            chk("shup.flushed", 32'(fl_n),  32'(i == 3));
        end
        chk("shup.final_q", q_n, 32'hFFFF_FFFF);
        drive(1'b1, SHUP, 8'hFF, 8'h00, 32'h0);
        chk("shup.sat_cnt", 32'(cnt_n), 32'd4);

        // Enable low blocks a pending shift-down.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, SHDN, 8'h00, 8'h77, 32'h0);
            chk("en0.q",   q_n,        32'hFFFF_FFFF);
            chk("en0.cnt", 32'(cnt_n), 32'd4);
        end
        drive(1'b1, LOAD, 8'h00, 8'h00, 32'h4433_2211);
        drive(1'b1, SHDN, 8'h00, 8'h77, 32'h0);
        chk("shdn.q",   q_n,        32'h7744_3322);
        chk("shdn.cnt", 32'(cnt_n), 32'd1);
        drive(1'b1, HOLD, 8'h12, 8'h34, 32'h5555_5555);
        chk("hold.q",   q_n,        32'h7744_3322);

        // Reset asserted while shifting, released mid-cycle after several edges.
        drive(1'b1, SHUP, 8'h5A, 8'h00, 32'h0);
        #1 reset = 1'b0;
        #1;
        chk("midrst.q_n",  q_n,        32'hA5A5_A5A5);
        chk("midrst.cnt",  32'(cnt_n), 32'd0);
        chk("midrst.fl",   32'(fl_n),  32'd0);
        chk("midrst.q_p",  q_p,        32'h3C3C_3C3C);
        #32 reset = 1'b1;
        @(negedge clk);
        #2;
        chk("resume.q_n",  q_n,        32'hA5A5_A55A);
        chk("resume.cnt",  32'(cnt_n), 32'd1);

`ifdef UNIV_SHIFT_REG_OVERRIDE_EN
        drive(1'b1, LOAD, 8'h00, 8'h00, 32'h4433_2211);
        ovr_val = 32'hDEAD_BEEF;
        ovr_en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, SHUP, 8'(i + 1), 8'h00, 32'h0);
            chk("ovr.q",       q_n,       32'hDEAD_BEEF);
            chk("ovr.sout_hi", 32'(hi_n), 32'(hi_seq[i]));
        end
        ovr_en = 1'b0;
        #1;
        chk("ovr.release_q", q_n, 32'h1101_0203);
`endif

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
`ifdef UNIV_SHIFT_REG_OVERRIDE_EN
            ovr_en  = ($urandom_range(0, 3) == 0);
            ovr_val = $urandom;
`endif
            drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom), $urandom);
            if ($urandom_range(0, 39) == 0) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end

        drive(1'b0, HOLD, 8'h00, 8'h00, 32'h0);
        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
